// File: rtl/serial_debug_pkg.sv
// Shared definitions for the serial debug chain: frame geometry, direction
// encoding and the node FSM state type.
package serial_debug_pkg;

  localparam int HDR_BITS = 16;
  localparam int ADDR_W   = 15;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  // Full store-forward frame width for a given payload width.
  function automatic int sf_bits(input int bits);
    return bits + HDR_BITS;
  endfunction

  // Field positions, MSB-first frame: {dir, addr[14:0], payload}.
  function automatic int dir_bit(input int bits);
    return bits + HDR_BITS - 1;
  endfunction

  function automatic int addr_msb(input int bits);
    return bits + HDR_BITS - 2;
  endfunction

  function automatic int addr_lsb(input int bits);
    return bits;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_PROC = 2'd2,
    ST_TX   = 2'd3
  } state_e;

endpackage

// File: rtl/serial_debug_sync.sv
// Three-flop synchronizer for the upstream serial clock/data pair plus a
// registered rising-edge detector on the synchronized clock. The clock chain
// resets high (line idle level) so leaving reset never fakes an edge.
module serial_debug_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_clk_i,
  input  logic rx_data_i,
  output logic rise_o,
  output logic data_o
);

  logic [2:0] clk_sync_q;
  logic [2:0] data_sync_q;
  logic       clk_prev_q;
  logic       rise_q;
  logic       data_q;

  // Synchronize both lines and flag a 0->1 transition of the synced clock;
  // data is delayed one stage so it lines up with the edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b000;
      clk_prev_q  <= 1'b1;
      rise_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], rx_clk_i};
      data_sync_q <= {data_sync_q[1:0], rx_data_i};
      clk_prev_q  <= clk_sync_q[2];
      rise_q      <= clk_sync_q[2] & ~clk_prev_q;
      data_q      <= data_sync_q[2];
    end
  end

  assign rise_o = rise_q;
  assign data_o = data_q;

endmodule

// File: rtl/serial_debug_node.sv
// Addressable store-and-forward node on the serial debug chain. Receives one
// frame, services a matching write/read, then retransmits the frame
// bit-serially downstream at the prescaler-defined rate.
// Optional feature macro: SERIAL_DEBUG_NODE_TIMEOUT_EN (RX idle abort).
module serial_debug_node
  import serial_debug_pkg::*;
#(
  parameter int unsigned BITS           = 128,
  parameter logic [14:0] NODE_ADDR      = 15'h0001,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      prescaler,
  input  logic            debug_rx_data,
  input  logic            debug_rx_clk,
  output logic            debug_tx_data,
  output logic            debug_tx_clk,
  input  logic [BITS-1:0] node_rd_data,
  output logic [BITS-1:0] node_wr_data,
  output logic            node_wr_strobe,
  output logic            node_rd_strobe,
  output logic            busy
);

  localparam int SF_BITS = sf_bits(BITS);
  localparam int DIR_BIT = dir_bit(BITS);
  localparam int A_MSB   = addr_msb(BITS);
  localparam int A_LSB   = addr_lsb(BITS);
  localparam int BCNT_W  = $clog2(SF_BITS + 1);
  localparam int HCNT_W  = $clog2(2 * SF_BITS + 2);

  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(SF_BITS - 1);
  localparam logic [HCNT_W-1:0] LAST_HALF = HCNT_W'(2 * SF_BITS);

  state_e               state_q, state_d;
  logic [SF_BITS-1:0]   frame_q, frame_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [HCNT_W-1:0]    half_cnt_q, half_cnt_d;
  logic [8:0]           presc_q, presc_d;
  logic                 tx_clk_q, tx_clk_d;
  logic                 tx_data_q, tx_data_d;
  logic [BITS-1:0]      wr_data_q, wr_data_d;
  logic                 wr_strobe_q, wr_strobe_d;
  logic                 rd_strobe_q, rd_strobe_d;
  logic                 busy_q, busy_d;

  logic       rx_rise;
  logic       rx_bit;
  logic       addr_hit;
  logic [8:0] presc_load;

  serial_debug_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_clk_i (debug_rx_clk),
    .rx_data_i(debug_rx_data),
    .rise_o   (rx_rise),
    .data_o   (rx_bit)
  );

  // Address 0 is reserved and never selects a node.
  assign addr_hit   = (frame_q[A_MSB:A_LSB] == NODE_ADDR) && (frame_q[A_MSB:A_LSB] != '0);
  assign presc_load = (prescaler == 8'd0) ? 9'd256 : {1'b0, prescaler};

`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  // Idle-cycle counter used to abandon a stalled partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  // Timeout length only matters when the idle counter is built.
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      half_cnt_q  <= '0;
      presc_q     <= '0;
      tx_clk_q    <= 1'b1;
      tx_data_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      half_cnt_q  <= half_cnt_d;
      presc_q     <= presc_d;
      tx_clk_q    <= tx_clk_d;
      tx_data_q   <= tx_data_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: receive, process, retransmit; edges outside IDLE/RX
  // are dropped so the chain stays strictly store-and-forward.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    half_cnt_d  = half_cnt_q;
    presc_d     = presc_q;
    tx_clk_d    = tx_clk_q;
    tx_data_d   = tx_data_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;
`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (rx_rise) begin
          frame_d   = {frame_q[SF_BITS-2:0], rx_bit};
          bit_cnt_d = BCNT_W'(1);
          busy_d    = 1'b1;
          state_d   = ST_RX;
`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
      end

      ST_RX: begin
        if (rx_rise) begin
          frame_d   = {frame_q[SF_BITS-2:0], rx_bit};
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = ST_PROC;
`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_LAST) begin
          idle_cnt_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_PROC: begin
        if (addr_hit) begin
          if (frame_q[DIR_BIT] == DIR_WRITE) begin
            wr_data_d   = frame_q[BITS-1:0];
            wr_strobe_d = 1'b1;
          end else begin
            frame_d[BITS-1:0] = node_rd_data;
            rd_strobe_d       = 1'b1;
          end
        end
        presc_d    = presc_load;
        half_cnt_d = '0;
        tx_clk_d   = 1'b1;
        state_d    = ST_TX;
      end

      ST_TX: begin
        if (presc_q == 9'd1) begin
          presc_d = presc_load;
          if (half_cnt_q == LAST_HALF) begin
            // Trailing high half-bit done: frame fully forwarded.
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            half_cnt_d = half_cnt_q + HCNT_W'(1);
            if (!half_cnt_q[0]) begin
              tx_data_d = frame_q[SF_BITS-1];
              frame_d   = {frame_q[SF_BITS-2:0], 1'b0};
              tx_clk_d  = 1'b0;
            end else begin
              tx_clk_d  = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q - 9'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign debug_tx_data  = tx_data_q;
  assign debug_tx_clk   = tx_clk_q;
  assign node_wr_data   = wr_data_q;
  assign node_wr_strobe = wr_strobe_q;
  assign node_rd_strobe = rd_strobe_q;
  assign busy           = busy_q;

endmodule
